// File: rtl/mc_control_if.sv
// mc_control_if: bus between the sequencer (master) and its datapath/memory (slave): opcode and mem_ready in; datapath controls, instr_done, sticky traps and debug state out
interface mc_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       PCSource;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state;
  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op, mem_timeout, state
  );
  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op, mem_timeout, state
  );
endinterface

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS-subset control FSM; ports clk, reset (sync, active-high) and bus (mc_control_if.master: opcode/mem_ready in, datapath controls and status out)
module mc_control #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  mc_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, BRANCH, EXEC_I, IWB, TRAP
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_t st, nxt;
  logic [CNT_W-1:0] cnt;
  logic waiting, expire;
  logic [5:0] op;
  assign op = bus.opcode;
  assign waiting = (st == FETCH || st == MEMRD || st == MEMWR) && !bus.mem_ready;
  assign expire = TIMEOUT_CYCLES != 0 && waiting && cnt >= LIM;
  assign bus.state = st;
  always_comb begin
    nxt = TRAP;
    case (st)
      FETCH:   nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE:  nxt = op == OP_R ? EXEC_R :
                     (op == OP_LW || op == OP_SW) ? MEMADDR :
                     op == OP_BEQ ? BRANCH :
                     (op == OP_ADDI || op == OP_ANDI || op == OP_ORI) ? EXEC_I : TRAP;
      MEMADDR: nxt = op == OP_LW ? MEMRD : MEMWR;
      MEMRD:   nxt = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:   nxt = bus.mem_ready ? FETCH : MEMWR;
      EXEC_R:  nxt = RWB;
      EXEC_I:  nxt = IWB;
      MEMWB, RWB, BRANCH, IWB: nxt = FETCH;
      default: nxt = TRAP;
    endcase
    if (expire) nxt = TRAP;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= FETCH;
      cnt <= '0;
      bus.illegal_op <= 1'b0;
      bus.mem_timeout <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= nxt != st ? '0 : (waiting && cnt != '1) ? cnt + 1'b1 : cnt;
      if (st == DECODE && nxt == TRAP) bus.illegal_op <= 1'b1;
      if (expire) bus.mem_timeout <= 1'b1;
    end
  end
  always_comb begin
    bus.PCWrite = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD = 1'b0;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegDst = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrcA = 1'b0;
    bus.ALUSrcB = 2'b00;
    bus.ALUOp = 3'b000;
    bus.PCSource = 1'b0;
    bus.instr_done = 1'b0;
    case (st)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.ALUOp = 3'b010;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        bus.ALUOp = 3'b010;
      end
      MEMADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ALUOp = 3'b010;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD = 1'b1;
      end
      MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        bus.instr_done = 1'b1;
      end
      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp = 3'b100;
      end
      RWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst = 1'b1;
        bus.instr_done = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp = 3'b011;
        bus.PCWriteCond = 1'b1;
        bus.PCSource = 1'b1;
        bus.instr_done = 1'b1;
      end
      EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ALUOp = op == OP_ANDI ? 3'b000 : op == OP_ORI ? 3'b001 : 3'b010;
      end
      IWB: begin
        bus.RegWrite = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized instruction streams with variable memory waits checked against a per-instruction state-sequence model, plus trap, timeout and reset scenarios
module tb_mc_control;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, JMP = 6'b000010;
  typedef struct {
    int   s;
    logic rdy;
  } step_t;
  logic clk = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;
  logic [16:0] ctrl;
  mc_control_if bus();
  mc_control #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                 bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                 bus.PCSource, bus.instr_done};
  function automatic logic [16:0] exp_ctrl(int s, logic [5:0] op, logic r);
    logic pcw = 0, pcc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0, pcs = 0, dn = 0;
    logic [1:0] sb = 2'b00;
    logic [2:0] ao = 3'b000;
    case (s)
      0: begin mr = 1; sb = 2'b01; ao = 3'b010; irw = r; pcw = r; end
      1: begin sb = 2'b11; ao = 3'b010; end
      2: begin sa = 1; sb = 2'b10; ao = 3'b010; end
      3: begin mr = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; dn = 1; end
      5: begin mw = 1; iord = 1; dn = r; end
      6: begin sa = 1; ao = 3'b100; end
      7: begin rw = 1; rd = 1; dn = 1; end
      8: begin sa = 1; ao = 3'b011; pcc = 1; pcs = 1; dn = 1; end
      9: begin sa = 1; sb = 2'b10; ao = op == ANDI ? 3'b000 : op == ORI ? 3'b001 : 3'b010; end
      10: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ao, pcs, dn};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  // Expected state trace: each memory wait contributes w cycles with mem_ready low then one with it high
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    step_t q[$];
    int done_cnt = 0;
    for (int i = 0; i <= fw; i++) q.push_back('{0, i == fw});
    q.push_back('{1, 1'($urandom)});
    case (op)
      R: begin q.push_back('{6, 1'($urandom)}); q.push_back('{7, 1'($urandom)}); end
      LW: begin
        q.push_back('{2, 1'($urandom)});
        for (int i = 0; i <= mw; i++) q.push_back('{3, i == mw});
        q.push_back('{4, 1'($urandom)});
      end
      SW: begin
        q.push_back('{2, 1'($urandom)});
        for (int i = 0; i <= mw; i++) q.push_back('{5, i == mw});
      end
      BEQ: q.push_back('{8, 1'($urandom)});
      default: begin q.push_back('{9, 1'($urandom)}); q.push_back('{10, 1'($urandom)}); end
    endcase
    foreach (q[k]) begin
      bus.opcode = q[k].s == 0 ? 6'($urandom) : op;
      bus.mem_ready = q[k].rdy;
      #1;
      chk($sformatf("state op=%b step%0d", op, k), 32'(bus.state), 32'(q[k].s));
      chk($sformatf("ctrl op=%b state%0d", op, q[k].s), 32'(ctrl), 32'(exp_ctrl(q[k].s, op, q[k].rdy)));
      done_cnt += 32'(bus.instr_done);
      tick();
    end
    chk($sformatf("done_pulses op=%b", op), 32'(done_cnt), 32'd1);
    chk("back_in_fetch", 32'(bus.state), 32'd0);
  endtask
  initial begin
    logic [5:0] legal [7] = '{R, LW, SW, BEQ, ADDI, ANDI, ORI};
    bus.opcode = 6'd0;
    bus.mem_ready = 1'b0;
    do_reset();
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_ctrl", 32'(ctrl), 32'(exp_ctrl(0, 6'd0, 1'b0)));
    chk("reset_flags", 32'({bus.illegal_op, bus.mem_timeout}), 32'd0);
    run_instr(R, 0, 0);
    run_instr(LW, 0, 3);
    run_instr(SW, 1, 2);
    run_instr(BEQ, 0, 0);
    run_instr(ANDI, 0, 0);
    run_instr(ORI, 2, 0);
    run_instr(ADDI, 3, 0);
    for (int n = 0; n < 40; n++)
      run_instr(legal[$urandom_range(0, 6)], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    chk("no_traps_after_stream", 32'({bus.illegal_op, bus.mem_timeout}), 32'd0);
    bus.mem_ready = 1'b1;
    tick();
    bus.opcode = JMP;
    #1;
    chk("illegal_decode_state", 32'(bus.state), 32'd1);
    tick();
    for (int i = 0; i < 22; i++) begin
      bus.mem_ready = 1'($urandom);
      bus.opcode = 6'($urandom);
      #1;
      chk("illegal_trap_state", 32'(bus.state), 32'd11);
      chk("illegal_trap_ctrl", 32'(ctrl), 32'd0);
      chk("illegal_flags", 32'({bus.illegal_op, bus.mem_timeout}), 32'b10);
      tick();
    end
    bus.mem_ready = 1'b0;
    do_reset();
    chk("illegal_reset_state", 32'(bus.state), 32'd0);
    chk("illegal_reset_flag", 32'(bus.illegal_op), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("timeout_wait_state", 32'(bus.state), 32'd0);
      tick();
    end
    chk("timeout_trap_state", 32'(bus.state), 32'd11);
    chk("timeout_flags", 32'({bus.illegal_op, bus.mem_timeout}), 32'b01);
    chk("timeout_trap_ctrl", 32'(ctrl), 32'd0);
    do_reset();
    chk("timeout_reset_flag", 32'(bus.mem_timeout), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    bus.mem_ready = 1'b1;
    tick();
    chk("timeout_boundary_decode", 32'(bus.state), 32'd1);
    chk("timeout_boundary_flag", 32'(bus.mem_timeout), 32'd0);
    bus.opcode = LW;
    tick();
    tick();
    bus.mem_ready = 1'b0;
    tick();
    tick();
    chk("midwait_state", 32'(bus.state), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midwait_reset_state", 32'(bus.state), 32'd0);
    chk("midwait_reset_writes", 32'({bus.PCWrite, bus.PCWriteCond, bus.MemWrite, bus.IRWrite, bus.RegWrite}), 32'd0);
    run_instr(LW, 3, 3);
    chk("midwait_no_timeout", 32'(bus.mem_timeout), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
